// File: rtl/dac_burst_scheduler_if.sv
// Sample stream link: tdata/tvalid/tlast flow master->slave,
// tready flows slave->master.
interface dac_burst_scheduler_if #(
  parameter int W = 32
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/dac_burst_scheduler.sv
// Gates the DAC sample stream into bursts with idle gaps and repeats,
// reseeding the DAC-core LFSR before every armed burst.
// Ports: aclk/aresetn, start/abort pulses, cfg_* run configuration,
// s_axis (from source), m_axis (to DAC core), lfsr_cfg/lfsr_flag,
// busy/done/lfsr_seen status.
module dac_burst_scheduler #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNT_WIDTH        = 32,
  parameter int LFSR_CFG_WIDTH   = 33
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      start,
  input  logic                      abort,
  input  logic [LFSR_CFG_WIDTH-1:0] cfg_lfsr,
  input  logic [CNT_WIDTH-1:0]      cfg_burst_len,
  input  logic [CNT_WIDTH-1:0]      cfg_gap_len,
  input  logic [CNT_WIDTH-1:0]      cfg_burst_num,
  dac_burst_scheduler_if.slave      s_axis,
  dac_burst_scheduler_if.master     m_axis,
  output logic [LFSR_CFG_WIDTH-1:0] lfsr_cfg,
  input  logic                      lfsr_flag,
  output logic                      busy,
  output logic                      done,
  output logic                      lfsr_seen
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    BURST,
    GAP
  } state_t;

  localparam logic [CNT_WIDTH-1:0] ONE =
    CNT_WIDTH'(1);
  localparam logic [LFSR_CFG_WIDTH-1:0] SRST =
    LFSR_CFG_WIDTH'(1) << 19;

  state_t                    state;
  logic                      arm_cnt;
  logic [CNT_WIDTH-1:0]      beat_cnt;
  logic [CNT_WIDTH-1:0]      burst_cnt;
  logic [CNT_WIDTH-1:0]      gap_cnt;
  logic [LFSR_CFG_WIDTH-1:0] lfsr_r;
  logic [CNT_WIDTH-1:0]      blen_r;
  logic [CNT_WIDTH-1:0]      glen_r;
  logic [CNT_WIDTH-1:0]      bnum_r;

  logic in_burst;
  logic beat;
  logic last_beat;

  assign in_burst  = (state == BURST);
  assign beat      = in_burst & s_axis.tvalid
                   & m_axis.tready;
  assign last_beat = (beat_cnt == blen_r - ONE);

  // Zero-latency pass-through; everything is
  // blocked outside BURST so the source stalls.
  assign m_axis.tdata  = {AXIS_TDATA_WIDTH{in_burst}}
                       & s_axis.tdata;
  assign m_axis.tvalid = in_burst & s_axis.tvalid;
  assign m_axis.tlast  = in_burst & last_beat;
  assign s_axis.tready = in_burst & m_axis.tready;

  assign busy = (state != IDLE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      arm_cnt   <= 1'b0;
      beat_cnt  <= '0;
      burst_cnt <= '0;
      gap_cnt   <= '0;
      lfsr_r    <= '0;
      blen_r    <= '0;
      glen_r    <= '0;
      bnum_r    <= '0;
      lfsr_cfg  <= '0;
      done      <= 1'b0;
      lfsr_seen <= 1'b0;
    end else begin
      done <= 1'b0;
      if (in_burst && lfsr_flag)
        lfsr_seen <= 1'b1;

      if (abort && state != IDLE) begin
        state <= IDLE;
        done  <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !abort) begin
              lfsr_r <= cfg_lfsr;
              blen_r <= cfg_burst_len;
              glen_r <= cfg_gap_len;
              bnum_r <= cfg_burst_num;
              if (cfg_burst_len == '0) begin
                done <= 1'b1;
              end else begin
                state     <= ARM;
                arm_cnt   <= 1'b0;
                beat_cnt  <= '0;
                burst_cnt <= '0;
                lfsr_seen <= 1'b0;
                lfsr_cfg  <= cfg_lfsr | SRST;
              end
            end
          end
          ARM: begin
            if (arm_cnt) begin
              state    <= BURST;
              lfsr_cfg <= lfsr_r & ~SRST;
            end else begin
              arm_cnt <= 1'b1;
            end
          end
          BURST: begin
            if (beat) begin
              if (last_beat) begin
                beat_cnt <= '0;
                // saturates for endless runs
                if (burst_cnt != '1)
                  burst_cnt <= burst_cnt + ONE;
                if (bnum_r != '0 &&
                    burst_cnt + ONE == bnum_r) begin
                  state <= IDLE;
                  done  <= 1'b1;
                end else if (glen_r != '0) begin
                  state   <= GAP;
                  gap_cnt <= '0;
                end
              end else begin
                beat_cnt <= beat_cnt + ONE;
              end
            end
          end
          GAP: begin
            if (gap_cnt == glen_r - ONE) begin
              state    <= ARM;
              arm_cnt  <= 1'b0;
              lfsr_cfg <= lfsr_r | SRST;
            end else begin
              gap_cnt <= gap_cnt + ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/dac_burst_scheduler.md
Name: dac_burst_scheduler

Overview:
- Sequences the Red Pitaya DAC sample stream into bursts of programmable length.
- Bursts are separated by programmable idle gaps and run for a programmable number of repetitions.
- Before each run it drives the LFSR configuration word of the DAC core, including a synchronous LFSR reset pulse.
- Sits between the sample source (AXIS) and the DAC core slave port, and is controlled from PS-side configuration registers.

Parameters:
AXIS_TDATA_WIDTH, 32, sample stream width (two 16-bit DAC channels)
CNT_WIDTH, 32, width of the burst length, gap length and repeat counters
LFSR_CFG_WIDTH, 33, width of the LFSR configuration word; bit 19 is the LFSR srst bit

Ports:
aclk  in  1  system clock; all logic is on its rising edge
aresetn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; starts a run when in IDLE, ignored otherwise
abort  in  1  one-cycle pulse; terminates a run from any state
cfg_lfsr  in  LFSR_CFG_WIDTH  LFSR configuration template
cfg_burst_len  in  CNT_WIDTH  beats per burst
cfg_gap_len  in  CNT_WIDTH  idle cycles between bursts
cfg_burst_num  in  CNT_WIDTH  bursts per run; 0 = run until abort
s_axis_tdata  in  AXIS_TDATA_WIDTH  source samples
s_axis_tvalid  in  1  source valid
s_axis_tready  out  1  source ready
m_axis_tdata  out  AXIS_TDATA_WIDTH  samples to the DAC core
m_axis_tvalid  out  1  valid to the DAC core
m_axis_tready  in  1  ready from the DAC core
m_axis_tlast  out  1  marks the last beat of each burst
lfsr_cfg  out  LFSR_CFG_WIDTH  configuration word to the DAC core LFSR
lfsr_flag  in  1  LFSR sequence flag from the DAC core
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a run completes or is aborted
lfsr_seen  out  1  sticky; lfsr_flag was sampled high during BURST in the current run

Behaviour:
- States: IDLE, ARM, BURST, GAP.
- Reset (aresetn low, asynchronous):
  - state = IDLE; all counters = 0.
  - lfsr_cfg = 0; busy = done = lfsr_seen = 0.
  - Registered config copies = 0.
- IDLE:
  - On start, latch all cfg_* inputs into internal registers. Later changes to cfg_* have no effect until the next start.
  - On start with cfg_burst_len = 0: pulse done next cycle and stay in IDLE.
  - On start with cfg_burst_len > 0: go to ARM, clear lfsr_seen, clear the burst counter.
- ARM:
  - Lasts exactly 2 cycles.
  - lfsr_cfg = latched cfg_lfsr with bit 19 forced to 1.
  - Then go to BURST; from then on lfsr_cfg = latched cfg_lfsr with bit 19 forced to 0, held until the next ARM.
- BURST (combinational pass-through, no added latency):
  - m_axis_tdata = s_axis_tdata.
  - m_axis_tvalid = s_axis_tvalid.
  - s_axis_tready = m_axis_tready.
  - A beat is accepted when m_axis_tvalid and m_axis_tready are both high. Each accepted beat increments the beat counter.
  - m_axis_tlast = 1 while beat counter = burst_len-1.
  - Any cycle with lfsr_flag high sets lfsr_seen.
- Last beat of a burst accepted:
  - Beat counter resets to 0; burst counter increments.
  - If burst_num != 0 and burst counter+1 = burst_num: pulse done, go to IDLE.
  - Else if gap_len = 0: stay in BURST (back-to-back bursts, no bubble).
  - Else: go to GAP.
- GAP:
  - m_axis_tvalid = 0; s_axis_tready = 0; source is stalled, no data dropped.
  - Counts gap_len cycles, then goes to ARM, so the LFSR is reseeded before every burst.
- Outside BURST: m_axis_tvalid = s_axis_tvalid... no: m_axis_tvalid = 0, s_axis_tready = 0, m_axis_tlast = 0.
- abort:
  - From any non-IDLE state: go to IDLE next cycle and pulse done.
  - m_axis_tvalid deasserts the cycle after abort.
  - abort in IDLE is ignored.
- start and abort in the same cycle: abort wins.
- Counters compare on full CNT_WIDTH values; there is no wrap-around. With burst_num = 0 the burst counter saturates at all-ones.
- busy = (state != IDLE).

Test Plan:
- burst_len=4, gap_len=3, burst_num=2, source always valid, tready=1: two 4-beat bursts with tlast on beats 4 and 8; tvalid low for 3 GAP cycles plus 2 ARM cycles between them; lfsr_cfg[19] high for 2 cycles before each burst; done pulses 1 cycle after beat 8.
- Same config but tready toggles 1/0 each cycle: exactly 8 beats accepted, no data lost, tlast only on accepted beats 4 and 8.
- gap_len=0, burst_len=3, burst_num=3: 9 consecutive accepted beats with no bubbles; tlast on beats 3, 6 and 9; a single ARM at the start only.
- burst_num=0 and burst_len=5, then abort at cycle 20: tvalid low from cycle 21, done pulse, busy=0, lfsr_cfg holds its last value.
- start with burst_len=0: done pulses next cycle, busy stays 0, tvalid never asserted.
- lfsr_flag pulsed during the 2nd burst: lfsr_seen=1 until the next start. Assert aresetn low mid-burst: all outputs 0 immediately.
